// File: rtl/byte_display_pkg.sv
// Shared constants, FSM state encoding and display-select helper for the
// UART byte display controller.
package byte_display_pkg;

  localparam int unsigned DATA_W              = 32'd8;
  localparam int unsigned NIBBLE_W            = 32'd4;
  localparam int unsigned HOLD_CYCLES_DEFAULT = 32'd25_000_000;

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } disp_state_e;

  // Mode 1 shows the running count, mode 0 the last received byte.
  function automatic logic [DATA_W-1:0] sel_display(
    input logic              mode,
    input logic [DATA_W-1:0] count,
    input logic [DATA_W-1:0] data
  );
    logic [DATA_W-1:0] v;
    if (mode) begin
      v = count;
    end else begin
      v = data;
    end
    return v;
  endfunction

endpackage

// File: rtl/byte_display_ctrl_if.sv
// Receiver-side inputs and display-side outputs of the byte display controller.
interface byte_display_ctrl_if import byte_display_pkg::*; ();

  logic                i_Rx_DV;
  logic [DATA_W-1:0]   i_Rx_Byte;
  logic                i_Mode;
  logic [NIBBLE_W-1:0] o_Upper_Nibble;
  logic [NIBBLE_W-1:0] o_Lower_Nibble;
  logic                o_Blank;
  logic [DATA_W-1:0]   o_Byte_Count;

  modport master (
    output i_Rx_DV, i_Rx_Byte, i_Mode,
    input  o_Upper_Nibble, o_Lower_Nibble, o_Blank, o_Byte_Count
  );

  modport slave (
    input  i_Rx_DV, i_Rx_Byte, i_Mode,
    output o_Upper_Nibble, o_Lower_Nibble, o_Blank, o_Byte_Count
  );

endinterface

// File: rtl/display_hold_timer.sv
// Down-counter that keeps a received byte on display for HOLD_CYCLES cycles;
// reloads on every strobe and parks at zero once the hold has elapsed.
module display_hold_timer
  import byte_display_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Load,
  output logic o_Expired
);

  localparam int unsigned     TW     = $clog2(HOLD_CYCLES);
  localparam logic [TW-1:0]   RELOAD = TW'(HOLD_CYCLES - 32'd1);

  logic [TW-1:0] r_Count;

  // Reload on strobe, otherwise count down and hold at zero.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_Count <= '0;
    end else if (i_Load) begin
      r_Count <= RELOAD;
    end else if (r_Count != '0) begin
      r_Count <= r_Count - TW'(1);
    end else begin
      r_Count <= r_Count;
    end
  end

  assign o_Expired = (r_Count == '0);

endmodule

// File: rtl/byte_display_ctrl.sv
// Latches UART bytes, counts strobes and drives two 7-segment nibbles,
// blanking the display once a byte has been shown for HOLD_CYCLES cycles.
module byte_display_ctrl
  import byte_display_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  byte_display_ctrl_if.slave  bus
);

  disp_state_e         r_State;
  disp_state_e         w_Next_State;
  logic [DATA_W-1:0]   r_Data;
  logic [DATA_W-1:0]   r_Count;
  logic [DATA_W-1:0]   w_Display;
  logic                w_Blank;
  logic                w_Expired;
  logic [NIBBLE_W-1:0] r_Upper;
  logic [NIBBLE_W-1:0] r_Lower;
  logic                r_Blank;
  logic [DATA_W-1:0]   r_Count_Out;

  display_hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold_timer (
    .i_Clk     (i_Clk),
    .i_Rst     (i_Rst),
    .i_Load    (bus.i_Rx_DV),
    .o_Expired (w_Expired)
  );

  // FSM state register.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_State <= ST_BLANK;
    end else begin
      r_State <= w_Next_State;
    end
  end

  // Next state: a strobe always wins over expiry, so back-to-back holds never gap.
  always_comb begin
    w_Next_State = r_State;
    case (r_State)
      ST_BLANK: begin
        if (bus.i_Rx_DV) begin
          w_Next_State = ST_SHOW;
        end else begin
          w_Next_State = ST_BLANK;
        end
      end
      ST_SHOW: begin
        if (bus.i_Rx_DV) begin
          w_Next_State = ST_SHOW;
        end else if (w_Expired) begin
          w_Next_State = ST_BLANK;
        end else begin
          w_Next_State = ST_SHOW;
        end
      end
      default: begin
        w_Next_State = ST_BLANK;
      end
    endcase
  end

  // Data register and modulo-256 strobe counter.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_Data  <= '0;
      r_Count <= '0;
    end else if (bus.i_Rx_DV) begin
      r_Data  <= bus.i_Rx_Byte;
      r_Count <= r_Count + DATA_W'(1);
    end else begin
      r_Data  <= r_Data;
      r_Count <= r_Count;
    end
  end

  // Display selection from the already-updated registers; count mode is never blanked.
  always_comb begin
    w_Display = sel_display(bus.i_Mode, r_Count, r_Data);
    w_Blank   = 1'b1;
    if (bus.i_Mode) begin
      w_Blank = 1'b0;
    end else if (r_State == ST_BLANK) begin
      w_Blank = 1'b1;
    end else begin
      w_Blank = 1'b0;
    end
  end

  // Registered outputs.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_Upper     <= 4'h0;
      r_Lower     <= 4'h0;
      r_Blank     <= 1'b1;
      r_Count_Out <= 8'h00;
    end else begin
      r_Upper     <= w_Display[7:4];
      r_Lower     <= w_Display[3:0];
      r_Blank     <= w_Blank;
      r_Count_Out <= r_Count;
    end
  end

  assign bus.o_Upper_Nibble = r_Upper;
  assign bus.o_Lower_Nibble = r_Lower;
  assign bus.o_Blank        = r_Blank;
  assign bus.o_Byte_Count   = r_Count_Out;

endmodule

// File: doc/byte_display_ctrl.md
BYTE_DISPLAY_CTRL -- requirements
Module: byte_display_ctrl

Interface
REQ-001 Parameter HOLD_CYCLES, default 25_000_000, is the number of i_Clk cycles a received byte stays displayed (1 s at 25 MHz); legal range 2..2^32-1.
REQ-002 i_Clk  input  1  sole clock; all logic on rising edge.
REQ-003 i_Rst  input  1  synchronous, active-high reset.
REQ-004 i_Rx_DV  input  1  one-cycle strobe from the UART receiver marking i_Rx_Byte valid.
REQ-005 i_Rx_Byte  input  8  received byte; sampled only when i_Rx_DV=1.
REQ-006 i_Mode  input  1  display source: 0 = last received byte, 1 = received-byte count.
REQ-007 o_Upper_Nibble  output  4  bits [7:4] of the displayed value; feeds the tens-digit 7-segment decoder.
REQ-008 o_Lower_Nibble  output  4  bits [3:0] of the displayed value; feeds the ones-digit 7-segment decoder.
REQ-009 o_Blank  output  1  1 = downstream forces both digits dark.
REQ-010 o_Byte_Count  output  8  running count of i_Rx_DV strobes.

Function
REQ-011 The block SHALL hold a data register, an 8-bit byte counter, a hold timer, and a two-state FSM: BLANK and SHOW.
REQ-012 When i_Rx_DV=1, the data register SHALL load i_Rx_Byte on that edge.
REQ-013 When i_Rx_DV=1, the byte counter SHALL increment by 1 on that edge, modulo 256 (255 -> 0, no saturation).
REQ-014 When i_Rx_DV=1, the hold timer SHALL load HOLD_CYCLES-1 on that edge.
REQ-015 When i_Rx_DV=1, the FSM SHALL enter SHOW on that edge, from either state.
REQ-016 In SHOW with i_Rx_DV=0, the timer SHALL decrement by 1 per cycle.
REQ-017 On the edge where the timer is 0 and i_Rx_DV=0, the FSM SHALL go SHOW -> BLANK; the SHOW state therefore lasts exactly HOLD_CYCLES cycles after the last strobe.
REQ-018 If i_Rx_DV=1 on the cycle the timer is 0, the reload SHALL win: the FSM stays in SHOW and the timer reloads, with no blank gap.
REQ-019 In BLANK, the timer SHALL hold at 0.
REQ-020 Outputs SHALL be registered; display value = i_Mode ? byte counter : data register, and the selection SHALL be taken from the already-updated registers.
REQ-021 A strobe at edge N SHALL be visible on o_Upper_Nibble/o_Lower_Nibble/o_Byte_Count after edge N+1 (1-cycle latency).
REQ-022 A change on i_Mode SHALL be reflected on the nibble outputs after 1 edge.
REQ-023 o_Blank SHALL be 1 in BLANK and 0 in SHOW when i_Mode=0.
REQ-024 When i_Mode=1, o_Blank SHALL be 0 regardless of FSM state; the count is always shown.
REQ-025 The FSM and timer SHALL keep running while i_Mode=1, so that returning to mode 0 reflects the true hold status.
REQ-026 Back-to-back strobes on consecutive cycles SHALL each be accepted; the counter advances by one per strobe and the last byte is displayed.

Reset
REQ-027 While i_Rst=1 at an edge, the FSM SHALL enter BLANK and the timer, data register and byte counter SHALL clear to 0.
REQ-028 While i_Rst=1 at an edge, o_Upper_Nibble, o_Lower_Nibble and o_Byte_Count SHALL be 0 and o_Blank SHALL be 1.
REQ-029 Reset SHALL take priority over a simultaneous i_Rx_DV; that strobe is dropped and not counted.
REQ-030 Reset asserted mid-SHOW SHALL abort the hold immediately.
REQ-031 After reset deassertion, the first output change SHALL require a new strobe, or an i_Mode change (which shows count 0x00).

Structure
REQ-032 A shared package byte_display_pkg SHALL hold the FSM state encoding (BLANK, SHOW), the HOLD_CYCLES default and the 8-bit data width constant.
REQ-033 The hold timer SHALL be a sub-module display_hold_timer with ports: clock, reset, load, expired flag, and HOLD_CYCLES parameter.
REQ-034 The FSM, data register, counter and output muxing SHALL remain in byte_display_ctrl.
REQ-035 The timer width SHALL be $clog2(HOLD_CYCLES).

Verification (HOLD_CYCLES=8 for all benches)
REQ-036 Reset, then one strobe with byte 0xA7, mode 0 -> after 1 edge: upper=0xA, lower=0x7, o_Blank=0, count=0x01; o_Blank returns to 1 exactly 8 cycles after the strobe edge.
REQ-037 Strobe with 0x3C, then strobe with 0x5E exactly on the timer-zero cycle -> o_Blank stays 0 continuously; display shows 0x5E; count=0x02.
REQ-038 256 strobes on consecutive cycles, last byte 0xFF -> count wraps to 0x00; with i_Mode=1 nibbles read 0x0/0x0 and o_Blank=0.
REQ-039 Strobe with 0x12, then assert i_Rst on cycle 3 of SHOW together with a strobe of 0x99 -> all outputs 0, o_Blank=1, count=0x00; the next strobe gives count=0x01.
REQ-040 Strobe with 0x42, wait 20 cycles, toggle i_Mode 0->1->0 -> mode 1 shows 0x01 unblanked; back in mode 0, o_Blank=1 within 1 edge.
